// File: rtl/pwm_ramp_controller_if.sv
// Configuration handshake bundle between the SPI register bank and the
// duty-cycle ramp controller.
//   cfg_valid     : a configuration request is present (master -> slave)
//   cfg_ready     : controller can accept a request     (slave -> master)
//   cfg_target    : requested final duty
//   cfg_step      : duty change per step, 0 means jump immediately
//   cfg_interval  : a step occurs every cfg_interval+1 cycles
//   cfg_immediate : jump straight to cfg_target
interface pwm_ramp_controller_if #(
  parameter int DUTY_W     = 8,
  parameter int INTERVAL_W = 16,
  parameter int STEP_W     = 4
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [DUTY_W-1:0]     cfg_target;
  logic [STEP_W-1:0]     cfg_step;
  logic [INTERVAL_W-1:0] cfg_interval;
  logic                  cfg_immediate;

  modport master (
    output cfg_valid, cfg_target, cfg_step, cfg_interval, cfg_immediate,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_target, cfg_step, cfg_interval, cfg_immediate,
    output cfg_ready
  );
endinterface

// File: rtl/pwm_ramp_controller.sv
// Walks the PWM duty register toward a requested target in fixed steps at a
// programmable interval, so duty changes seen by the PWM peripheral are
// gradual. Sits between the SPI register bank and pwm_peripheral.
//   clk, rst   : system clock, synchronous active-high reset
//   cfg        : configuration handshake (slave side)
//   lock       : blocks new configuration (cfg_ready = !lock)
//   hold       : freezes an active ramp (counter, duty, state)
//   duty_out   : registered duty, drives pwm_duty_cycle
//   target_out : latched target for status readback
//   busy       : high while ramping
//   done       : one-cycle pulse in the cycle duty_out reaches the target
module pwm_ramp_controller #(
  parameter int DUTY_W     = 8,
  parameter int INTERVAL_W = 16,
  parameter int STEP_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  pwm_ramp_controller_if.slave  cfg,
  input  logic                  lock,
  input  logic                  hold,
  output logic [DUTY_W-1:0]     duty_out,
  output logic [DUTY_W-1:0]     target_out,
  output logic                  busy,
  output logic                  done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RAMP = 1'b1;

  // One step toward target, evaluated one bit wider than the duty so the
  // sum cannot wrap and the difference cannot underflow; the result
  // saturates at the target from either side.
  function automatic logic [DUTY_W-1:0] step_toward(
    input logic [DUTY_W-1:0] duty,
    input logic [DUTY_W-1:0] target,
    input logic [STEP_W-1:0] step
  );
    logic [DUTY_W:0] d_ext;
    logic [DUTY_W:0] t_ext;
    logic [DUTY_W:0] s_ext;
    logic [DUTY_W:0] sum;
    logic [DUTY_W:0] diff;
    d_ext = {1'b0, duty};
    t_ext = {1'b0, target};
    s_ext = (DUTY_W+1)'(step);
    sum   = d_ext + s_ext;
    diff  = d_ext - s_ext;
    step_toward = duty;
    if (d_ext < t_ext) begin
      step_toward = (sum >= t_ext) ? target : sum[DUTY_W-1:0];
    end else if (d_ext > t_ext) begin
      step_toward = (d_ext <= t_ext + s_ext) ? target : diff[DUTY_W-1:0];
    end
  endfunction

  logic [0:0]            state_q,    state_d;
  logic [DUTY_W-1:0]     duty_q,     duty_d;
  logic [DUTY_W-1:0]     target_q,   target_d;
  logic [STEP_W-1:0]     step_q,     step_d;
  logic [INTERVAL_W-1:0] interval_q, interval_d;
  logic [INTERVAL_W-1:0] cnt_q,      cnt_d;
  logic                  done_q,     done_d;

  logic                  accept;
  logic [DUTY_W-1:0]     next_duty;

  assign cfg.cfg_ready = !lock;
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign next_duty     = step_toward(duty_q, target_q, step_q);

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    target_d   = target_q;
    step_d     = step_q;
    interval_d = interval_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;

    // A new request always wins over a pending step on the same edge.
    if (accept) begin
      if (cfg.cfg_immediate || (cfg.cfg_step == '0)) begin
        duty_d   = cfg.cfg_target;
        target_d = cfg.cfg_target;
        state_d  = ST_IDLE;
        done_d   = 1'b1;
      end else begin
        target_d   = cfg.cfg_target;
        step_d     = cfg.cfg_step;
        interval_d = cfg.cfg_interval;
        cnt_d      = '0;
        if (cfg.cfg_target == duty_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RAMP;
        end
      end
    end else if ((state_q == ST_RAMP) && !hold) begin
      if (cnt_q != interval_q) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d  = '0;
        duty_d = next_duty;
        if (next_duty == target_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      duty_q     <= '0;
      target_q   <= '0;
      step_q     <= '0;
      interval_q <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      target_q   <= target_d;
      step_q     <= step_d;
      interval_q <= interval_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
    end
  end

  assign duty_out   = duty_q;
  assign target_out = target_q;
  assign busy       = (state_q == ST_RAMP);
  assign done       = done_q;

endmodule
